// File: rtl/debug_view_ctrl_if.sv
// Debug-view bus: channel inputs, view controls and step button toward the
// controller, displayed word, 7-seg digits and step pulse back out.
interface debug_view_ctrl_if #(
  parameter int unsigned N_CH = 8,
  parameter int unsigned DW   = 16
);
  localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*DW-1:0]    ch_data;
  logic [SEL_W-1:0]      sel;
  logic [1:0]            mode;
  logic                  step_btn;
  logic                  step_en;
  logic [SEL_W-1:0]      view_ch;
  logic [DW-1:0]         view_data;
  logic [7*(DW/4)-1:0]   hex_seg;
  logic                  frozen;

  // Board/bench side
  modport master (
    output ch_data, sel, mode, step_btn,
    input  step_en, view_ch, view_data, hex_seg, frozen
  );

  // Controller side
  modport slave (
    input  ch_data, sel, mode, step_btn,
    output step_en, view_ch, view_data, hex_seg, frozen
  );
endinterface

// File: rtl/debug_view_ctrl.sv
// Debug-display controller: picks one of N_CH debug words (manual, auto-scan
// or frozen), shows it on active-low 7-seg digits, and debounces the step
// pushbutton into a single-cycle step_en.
module debug_view_ctrl #(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned DW       = 16,
  parameter int unsigned SCAN_DIV = 50_000_000,
  parameter int unsigned DEB_CYC  = 500_000
) (
  input logic              clock_i,
  input logic              reset_i,
  debug_view_ctrl_if.slave dbg_if
);
  localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned ND    = DW / 4;
  localparam int unsigned SCW   = $clog2(SCAN_DIV);
  localparam int unsigned DBW   = $clog2(DEB_CYC + 1);

  localparam logic [SCW-1:0]   ScanLast = SCW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0]   DebLast  = DBW'(DEB_CYC - 1);
  localparam logic [SEL_W-1:0] ChLast   = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {
    ModeManual = 2'b00,
    ModeScan   = 2'b01,
    ModeFreeze = 2'b10,
    ModeAlt    = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(dbg_if.mode);

  logic [SEL_W-1:0] view_ch_q, view_ch_d;
  logic [DW-1:0]    view_data_q, view_data_d;
  logic [SCW-1:0]   scan_cnt_q, scan_cnt_d;
  logic             frozen_q, frozen_d;
  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic [DBW-1:0]   deb_cnt_q, deb_cnt_d;
  logic             step_en_q, step_en_d;

  // Out-of-range indices (non-power-of-two N_CH) read as zero.
  function automatic logic [DW-1:0] pick(input logic [N_CH*DW-1:0] data,
                                         input logic [SEL_W-1:0]   idx);
    logic [DW-1:0] word;
    word = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) word = data[k*DW +: DW];
    end
    return word;
  endfunction

  // Active-low glyphs, bit order g..a.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // View next-state: manual follows sel, scan rotates on terminal count, freeze holds.
  always_comb begin
    view_ch_d   = view_ch_q;
    view_data_d = view_data_q;
    scan_cnt_d  = '0;
    frozen_d    = 1'b0;
    unique case (mode)
      ModeScan: begin
        view_data_d = pick(dbg_if.ch_data, view_ch_q);
        if (scan_cnt_q == ScanLast) begin
          view_ch_d = (view_ch_q >= ChLast) ? '0 : view_ch_q + SEL_W'(1);
        end else begin
          scan_cnt_d = scan_cnt_q + SCW'(1);
        end
      end
      ModeFreeze: frozen_d = 1'b1;
      default: begin
        view_ch_d   = dbg_if.sel;
        view_data_d = pick(dbg_if.ch_data, dbg_if.sel);
      end
    endcase
  end

  // Debounce next-state: accept a new level after DEB_CYC consecutive mismatching cycles.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    step_en_d = 1'b0;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == DebLast) begin
        deb_d     = sync_q[1];
        step_en_d = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + DBW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      view_ch_q   <= '0;
      view_data_q <= '0;
      scan_cnt_q  <= '0;
      frozen_q    <= 1'b0;
      sync_q      <= '0;
      deb_q       <= 1'b0;
      deb_cnt_q   <= '0;
      step_en_q   <= 1'b0;
    end else begin
      view_ch_q   <= view_ch_d;
      view_data_q <= view_data_d;
      scan_cnt_q  <= scan_cnt_d;
      frozen_q    <= frozen_d;
      sync_q      <= {sync_q[0], dbg_if.step_btn};
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      step_en_q   <= step_en_d;
    end
  end

  // Digit decode of the registered word, nibble i onto digit i.
  always_comb begin
    dbg_if.hex_seg = '0;
    for (int unsigned i = 0; i < ND; i++) begin
      dbg_if.hex_seg[7*i +: 7] = seg7(view_data_q[4*i +: 4]);
    end
  end

  assign dbg_if.view_ch   = view_ch_q;
  assign dbg_if.view_data = view_data_q;
  assign dbg_if.frozen    = frozen_q;
  assign dbg_if.step_en   = step_en_q;

endmodule

// File: tb/tb_debug_view_ctrl.sv
// Bench for debug_view_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_debug_view_ctrl;
  localparam int unsigned N_CH     = 4;
  localparam int unsigned DW       = 8;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB_CYC  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  debug_view_ctrl_if #(.N_CH(N_CH), .DW(DW)) dif ();

  debug_view_ctrl #(
    .N_CH    (N_CH),
    .DW      (DW),
    .SCAN_DIV(SCAN_DIV),
    .DEB_CYC (DEB_CYC)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .dbg_if (dif)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Behavioural model: what is shown, how long it has been shown, and the
  // button history seen through two synchroniser stages.
  int         m_ch, m_dwell, m_run, md;
  logic [7:0] m_data;
  bit         m_frz, m_step, m_deb, m_s1, m_s2;

  always @(posedge clock) begin
    if (reset) begin
      m_ch = 0; m_data = 8'h00; m_frz = 0; m_dwell = 0;
      m_step = 0; m_deb = 0; m_run = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      md = (dif.mode == 2'd3) ? 0 : int'(dif.mode);
      if (md == 0) begin
        m_ch = int'(dif.sel);
        m_data = (m_ch < N_CH) ? dif.ch_data[m_ch*DW +: DW] : 8'h00;
        m_dwell = 0; m_frz = 0;
      end else if (md == 1) begin
        m_data = dif.ch_data[m_ch*DW +: DW];
        m_frz = 0;
        if (m_dwell == SCAN_DIV - 1) begin
          m_dwell = 0;
          m_ch = (m_ch + 1) % N_CH;
        end else begin
          m_dwell++;
        end
      end else begin
        m_frz = 1; m_dwell = 0;
      end
      m_step = 0;
      if (m_s2 != m_deb) begin
        m_run++;
        if (m_run == DEB_CYC) begin
          m_deb = m_s2; m_run = 0; m_step = m_deb;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = dif.step_btn;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_view_ch", 32'(dif.view_ch), m_ch);
      chk("model_view_data", 32'(dif.view_data), 32'(m_data));
      chk("model_frozen", 32'(dif.frozen), 32'(m_frz));
      chk("model_step_en", 32'(dif.step_en), 32'(m_step));
      chk("model_hex_seg", 32'(dif.hex_seg), 32'({glyph(m_data[7:4]), glyph(m_data[3:0])}));
    end
  end

  int pulses, first_at;

  initial begin
    dif.ch_data = {8'h43, 8'h32, 8'h21, 8'h10};
    dif.sel = '0; dif.mode = 2'b00; dif.step_btn = 1'b0;

    // Reset held two cycles
    @(negedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    chk("rst_view_ch", 32'(dif.view_ch), 0);
    chk("rst_view_data", 32'(dif.view_data), 32'h00);
    chk("rst_hex_seg", 32'(dif.hex_seg), 32'h2040);
    chk("rst_step_en", 32'(dif.step_en), 0);
    chk("rst_frozen", 32'(dif.frozen), 0);

    // Manual select
    reset = 1'b0; dif.sel = 2'd2;
    @(negedge clock);
    chk("man_sel2_data", 32'(dif.view_data), 32'h32);
    chk("man_sel2_ch", 32'(dif.view_ch), 2);
    dif.sel = 2'd3;
    @(negedge clock);
    chk("man_sel3_data", 32'(dif.view_data), 32'h43);
    chk("man_sel3_hex", 32'(dif.hex_seg), 32'h0CB0);

    // Auto-scan from channel 0, sel ignored
    dif.sel = 2'd0;
    @(negedge clock);
    dif.mode = 2'b01; dif.sel = 2'd3;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      chk("scan_ch", 32'(dif.view_ch), (k / 4) % 4);
    end

    // Freeze mid-dwell, then resume manual
    @(negedge clock);
    dif.mode = 2'b10;
    @(negedge clock);
    chk("frz_flag", 32'(dif.frozen), 1);
    chk("frz_entry_data", 32'(dif.view_data), 32'h21);
    dif.ch_data[15:8] = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("frz_hold_data", 32'(dif.view_data), 32'h21);
    end
    dif.mode = 2'b00; dif.sel = 2'd1;
    @(negedge clock);
    chk("frz_exit_data", 32'(dif.view_data), 32'hA5);
    chk("frz_exit_flag", 32'(dif.frozen), 0);

    // Bouncing press then steady level
    dif.step_btn = 1'b1;
    @(negedge clock);
    dif.step_btn = 1'b0;
    @(negedge clock);
    dif.step_btn = 1'b1;
    pulses = 0; first_at = -1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      if (dif.step_en === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
    end
    chk("step_press_pulses", pulses, 1);
    chk("step_press_at", first_at, 5);
    dif.step_btn = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (dif.step_en === 1'b1) pulses++;
    end
    chk("step_release_pulses", pulses, 0);

    // Reset during scan at count 2 on channel 3
    dif.sel = 2'd3;
    @(negedge clock);
    dif.mode = 2'b01;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_view_ch", 32'(dif.view_ch), 0);
    chk("midrst_view_data", 32'(dif.view_data), 0);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk("post_reset_scan", 32'(dif.view_ch), (k / 4) % 4);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 15) == 0) dif.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) dif.sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) dif.ch_data = $urandom;
      if ($urandom_range(0, 7) == 0) dif.step_btn = ~dif.step_btn;
    end
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
